// File: rtl/mem_access_ctrl.sv
// Data-side memory access controller: turns CPU byte/word load/store requests
// into word-addressed memory strobes with byte-lane enables, with timeout and alignment errors.
`timescale 1ns/1ps

module mem_access_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int TIMEOUT     = 8,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_byte,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]           cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic [15:0]           cpu_rdata,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-2:0] mem_rd_addr,
  input  logic [15:0]           mem_rd_data,
  input  logic                  mem_rd_done,
  output logic [1:0]            mem_wr_en,
  output logic [ADDR_WIDTH-2:0] mem_wr_addr,
  output logic [15:0]           mem_wr_data,
  input  logic                  mem_wr_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic            r_byte;
  logic            r_lsb;
  logic            r_err;
  logic [15:0]     r_rdata;

  logic            w_misaligned;
  logic            w_timeout;
  logic [7:0]      w_byte_sel;
  logic [1:0]      w_wr_be;
  logic [15:0]     w_wr_data;
  logic [15:0]     w_load_data;

  assign w_misaligned = ALIGN_CHECK && !cpu_byte && cpu_addr[0];
  // The counter starts at 0 on the first wait cycle, so TIMEOUT-1 marks the last allowed one.
  assign w_timeout    = (r_cnt == CW'(TIMEOUT - 1));
  assign w_byte_sel   = r_lsb ? mem_rd_data[15:8] : mem_rd_data[7:0];
  assign w_load_data  = r_byte ? {8'h00, w_byte_sel} : mem_rd_data;
  assign w_wr_be      = cpu_byte ? (cpu_addr[0] ? 2'b10 : 2'b01) : 2'b11;
  assign w_wr_data    = cpu_byte ? {cpu_wdata[7:0], cpu_wdata[7:0]} : cpu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_lsb       <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 16'h0000;
      cpu_ack     <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= 16'h0000;
      busy        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 2'b00;
      mem_wr_addr <= '0;
      mem_wr_data <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          cpu_ack <= 1'b0;
          cpu_err <= 1'b0;
          if (cpu_req) begin
            r_we   <= cpu_we;
            r_byte <= cpu_byte;
            r_lsb  <= cpu_addr[0];
            r_cnt  <= '0;
            busy   <= 1'b1;
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (cpu_we) begin
              r_err       <= 1'b0;
              mem_wr_en   <= w_wr_be;
              mem_wr_addr <= cpu_addr[ADDR_WIDTH-1:1];
              mem_wr_data <= w_wr_data;
              r_state     <= S_WR_WAIT;
            end else begin
              r_err       <= 1'b0;
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= cpu_addr[ADDR_WIDTH-1:1];
              r_state     <= S_RD_WAIT;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_RD_WAIT: begin
          if (mem_rd_done) begin
            mem_rd_en <= 1'b0;
            r_rdata   <= w_load_data;
            r_err     <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_timeout) begin
            mem_rd_en <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WR_WAIT: begin
          if (mem_wr_done) begin
            mem_wr_en <= 2'b00;
            r_err     <= 1'b0;
            r_state   <= S_DONE;
          end else if (w_timeout) begin
            mem_wr_en <= 2'b00;
            r_err     <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          cpu_ack <= 1'b1;
          cpu_err <= r_err;
          // Load data only becomes visible together with a successful ack.
          if (!r_err && !r_we) begin
            cpu_rdata <= r_rdata;
          end else begin
            cpu_rdata <= cpu_rdata;
          end
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          mem_rd_en <= 1'b0;
          mem_wr_en <= 2'b00;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a negedge-active byte-writable memory model.
`timescale 1ns/1ps

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_byte = 1'b0;
  logic [15:0] cpu_addr = 16'h0000, cpu_wdata = 16'h0000;
  logic        cpu_ack, cpu_err, busy, mem_rd_en;
  logic [15:0] cpu_rdata, mem_wr_data;
  logic [14:0] mem_rd_addr, mem_wr_addr;
  logic [1:0]  mem_wr_en;
  logic [15:0] mem_rd_data = 16'h0000;
  logic        mem_rd_done = 1'b0, mem_wr_done = 1'b0;
  logic        rd_block = 1'b0, wr_block = 1'b0;
  logic [15:0] mem [0:255];

  // second instance without alignment checking
  logic        req2 = 1'b0;
  logic [15:0] addr2 = 16'h0000;
  logic        ack2, err2, busy2, rd_en2;
  logic [15:0] rdata2, wr_data2;
  logic [14:0] rd_addr2, wr_addr2;
  logic [1:0]  wr_en2;
  logic [15:0] rd_data2 = 16'h0000;
  logic        rd_done2 = 1'b0;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
    logic        load;
  } exp_t;
  exp_t sb_q[$];

  int n_total = 0;
  int n_bad = 0;

  logic        f_rd_en;
  logic [14:0] f_rd_addr;
  logic [1:0]  f_wr_en;
  logic [15:0] f_wr_data;

  mem_access_ctrl #(.ADDR_WIDTH(16), .TIMEOUT(8), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .busy(busy), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_done(mem_rd_done), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_done(mem_wr_done)
  );

  mem_access_ctrl #(.ADDR_WIDTH(16), .TIMEOUT(8), .ALIGN_CHECK(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .cpu_req(req2), .cpu_we(1'b0), .cpu_byte(1'b0),
    .cpu_addr(addr2), .cpu_wdata(16'h0000), .cpu_ack(ack2), .cpu_err(err2),
    .cpu_rdata(rdata2), .busy(busy2), .mem_rd_en(rd_en2), .mem_rd_addr(rd_addr2),
    .mem_rd_data(rd_data2), .mem_rd_done(rd_done2), .mem_wr_en(wr_en2),
    .mem_wr_addr(wr_addr2), .mem_wr_data(wr_data2), .mem_wr_done(1'b0)
  );

  always #5 clk = ~clk;

  // negedge-active memory: done is raised the negedge after a strobe is seen
  always @(negedge clk) begin
    mem_rd_done <= mem_rd_en && !rd_block;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:0]];
    mem_wr_done <= (mem_wr_en != 2'b00) && !wr_block;
    if (mem_wr_en[0]) mem[mem_wr_addr[7:0]][7:0]  <= mem_wr_data[7:0];
    if (mem_wr_en[1]) mem[mem_wr_addr[7:0]][15:8] <= mem_wr_data[15:8];
    rd_done2 <= rd_en2;
    rd_data2 <= {rd_addr2, 1'b1} ^ 16'h5A5A;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input string tag, input logic we, input logic bt,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic exp_err, input logic [15:0] exp_rdata, input int exp_lat);
    exp_t e;
    int   lat;
    bit   got;
    e.err = exp_err; e.rdata = exp_rdata; e.lat = exp_lat; e.load = !we;
    sb_q.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_byte = bt; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    lat = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        f_rd_en = mem_rd_en; f_rd_addr = mem_rd_addr; f_wr_en = mem_wr_en; f_wr_data = mem_wr_data;
      end
      if (cpu_ack) got = 1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    cpu_req = 1'b0;
    e = sb_q.pop_front();
    check_eq({tag, "_ack_seen"}, 32'(got), 32'd1);
    check_eq({tag, "_latency"}, lat, e.lat);
    check_eq({tag, "_err"}, 32'(cpu_err), 32'(e.err));
    if (e.load) check_eq({tag, "_rdata"}, 32'(cpu_rdata), 32'(e.rdata));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8]  = 16'hBEEF;
    mem[16] = 16'h1234;
    #1;
    check_eq("rst_outs", {cpu_ack, cpu_err, busy, mem_rd_en, mem_wr_en}, 32'd0);
    check_eq("rst_rdata", 32'(cpu_rdata), 32'd0);
    check_eq("rst_addrs", {mem_rd_addr, mem_wr_addr}, 32'd0);
    check_eq("rst_wdata", 32'(mem_wr_data), 32'd0);
    check_eq("rst2_outs", {ack2, err2, busy2, rd_en2, wr_en2, rdata2}, 32'd0);
    check_eq("rst2_addrs", {rd_addr2, wr_addr2}, 32'd0);
    check_eq("rst2_wdata", 32'(wr_data2), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_access("wload", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 2);
    check_eq("wload_rd_en", 32'(f_rd_en), 32'd1);
    check_eq("wload_rd_addr", 32'(f_rd_addr), 32'h0008);
    check_eq("wload_no_wr", 32'(f_wr_en), 32'd0);
    do_access("bload_hi", 1'b0, 1'b1, 16'h0011, 16'h0000, 1'b0, 16'h00BE, 2);
    do_access("bload_lo", 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h00EF, 2);
    do_access("bstore_hi", 1'b1, 1'b1, 16'h0021, 16'h00A5, 1'b0, 16'h0000, 2);
    check_eq("bstore_hi_be", 32'(f_wr_en), 32'b10);
    check_eq("bstore_hi_data", 32'(f_wr_data), 32'hA5A5);
    check_eq("bstore_hi_addr", 32'(mem_wr_addr), 32'h0010);
    do_access("rb_word16", 1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hA534, 2);
    do_access("wstore", 1'b1, 1'b0, 16'h0040, 16'hCAFE, 1'b0, 16'h0000, 2);
    check_eq("wstore_be", 32'(f_wr_en), 32'b11);
    check_eq("wstore_data", 32'(f_wr_data), 32'hCAFE);
    do_access("bload_w32", 1'b0, 1'b1, 16'h0040, 16'h0000, 1'b0, 16'h00FE, 2);
    do_access("bstore_lo", 1'b1, 1'b1, 16'h0040, 16'hFF77, 1'b0, 16'h0000, 2);
    check_eq("bstore_lo_be", 32'(f_wr_en), 32'b01);
    check_eq("bstore_lo_data", 32'(f_wr_data), 32'h7777);
    do_access("rb_word32", 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'hCA77, 2);

    do_access("misal_ld", 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'hCA77, 1);
    check_eq("misal_ld_nostrobe", {f_rd_en, f_wr_en}, 32'd0);
    do_access("misal_st", 1'b1, 1'b0, 16'h0005, 16'h1111, 1'b1, 16'h0000, 1);
    check_eq("misal_st_nostrobe", {f_rd_en, f_wr_en}, 32'd0);

    rd_block = 1'b1;
    do_access("tmo_ld", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hCA77, 9);
    @(negedge clk);
    check_eq("tmo_rd_en_low", 32'(mem_rd_en), 32'd0);
    check_eq("tmo_busy_low", 32'(busy), 32'd0);
    rd_block = 1'b0;

    // reset in the middle of a blocked write
    wr_block = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    check_eq("rstmid_wr_en", 32'(mem_wr_en), 32'b11);
    check_eq("rstmid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check_eq("rstmid_strobe_drop", {mem_wr_en, mem_rd_en}, 32'd0);
    check_eq("rstmid_busy_drop", 32'(busy), 32'd0);
    check_eq("rstmid_no_ack", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    wr_block = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstmid_no_ack_after", 32'(cpu_ack), 32'd0);
    check_eq("rstmid_rdata_cleared", 32'(cpu_rdata), 32'd0);
    do_access("post_rst_ld", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 2);

    // misaligned word load without alignment checking goes to word 1
    begin
      int  lat2;
      bit  got2;
      @(negedge clk);
      req2 = 1'b1; addr2 = 16'h0003;
      @(posedge clk);
      lat2 = 0; got2 = 0;
      for (int i = 0; i < 40 && !got2; i++) begin
        @(negedge clk);
        if (i == 0) check_eq("noalign_rd_addr", 32'(rd_addr2), 32'h0001);
        if (ack2) got2 = 1;
        else begin
          @(posedge clk);
          lat2++;
        end
      end
      req2 = 1'b0;
      check_eq("noalign_ack_seen", 32'(got2), 32'd1);
      check_eq("noalign_latency", lat2, 2);
      check_eq("noalign_err", 32'(err2), 32'd0);
      check_eq("noalign_rdata", 32'(rdata2), 32'(16'h0003 ^ 16'h5A5A));
      check_eq("noalign_no_wr", 32'(wr_en2), 32'd0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
